// File: rtl/pcie_pkg.sv
// ============================================================================
// Module      : pcie_pkg
// Description : Shared constants and types for the PCIe TX TLP multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_pkg;

    // Width of a 4DW TLP header.
    localparam int TLP_HDR_WIDTH    = 128;
    // Fmt[1] of DW0: set when the TLP carries a payload.
    localparam int HDR_FMT_DATA_BIT = 30;
    // Beat width toward the PIPE/DLL.
    localparam int PIPE_DATA_WIDTH  = 256;

    // Output sequencing: headers are issued in IDLE, payload beats in PLD.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLD  = 1'b1
    } tx_mux_state_t;

    // Index width for NUM_CH channels; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_rr_arbiter.sv
// ============================================================================
// Module      : pcie_rr_arbiter
// Description : Combinational round-robin search starting at ptr_i; returns a
//               one-hot grant of the first requesting channel at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_rr_arbiter
    import pcie_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic              valid_o
);

    logic [IDX_W-1:0] cand;

    // Walk channels ptr, ptr+1, ... (mod NUM_CH) and take the first request.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_CH);
            if (!valid_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcie_tx_tlp_mux.sv
// ============================================================================
// Module      : pcie_tx_tlp_mux
// Description : Merges NUM_CH show-ahead TLP header queues and one shared
//               payload queue into a single registered valid/ready TLP stream.
//               Headers are arbitrated round-robin; a header with Fmt[1] set
//               is followed by payload beats up to pld_last_i.
//               Optional statistics counters: define PCIE_TX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_tx_tlp_mux
    import pcie_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int HDR_WIDTH  = TLP_HDR_WIDTH,
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                hdr_empty_i,
    input  logic [NUM_CH-1:0][HDR_WIDTH-1:0] hdr_rdata_i,
    output logic [NUM_CH-1:0]                hdr_rden_o,
    input  logic                             pld_empty_i,
    input  logic [DATA_WIDTH-1:0]            pld_rdata_i,
    input  logic                             pld_last_i,
    output logic                             pld_rden_o,
    output logic                             tlp_valid_o,
    input  logic                             tlp_ready_i,
    output logic [DATA_WIDTH-1:0]            tlp_data_o,
    output logic                             tlp_sop_o,
    output logic                             tlp_eop_o,
    output logic [NUM_CH-1:0][31:0]          stat_tlp_cnt_o,
    output logic [31:0]                      stat_stall_cnt_o
);

    localparam int IDX_W = idx_width(NUM_CH);

    tx_mux_state_t          state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;

    logic [NUM_CH-1:0]      gnt;
    logic                   arb_valid;
    logic [IDX_W-1:0]       gnt_idx;
    logic [HDR_WIDTH-1:0]   sel_hdr;
    logic                   has_data;
    logic                   load_en;
    logic [NUM_CH-1:0]      hdr_rden;
    logic                   pld_rden;

    pcie_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i   (~hdr_empty_i),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .valid_o (arb_valid)
    );

    // Convert the one-hot grant into an index to select the header word.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) begin
                gnt_idx = IDX_W'(k);
            end
        end
    end

    assign sel_hdr  = hdr_rdata_i[gnt_idx];
    assign has_data = sel_hdr[HDR_FMT_DATA_BIT];
    assign load_en  = !valid_q || tlp_ready_i;

    // Next-state, output-stage load and pop strobes.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        hdr_rden = '0;
        pld_rden = 1'b0;
        if (load_en) begin
            valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        hdr_rden = gnt;
                        valid_d  = 1'b1;
                        data_d   = '0;
                        data_d[HDR_WIDTH-1:0] = sel_hdr;
                        sop_d    = 1'b1;
                        eop_d    = !has_data;
                        ptr_d    = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                        if (has_data) begin
                            state_d = ST_PLD;
                        end
                    end
                end
                ST_PLD: begin
                    if (!pld_empty_i) begin
                        pld_rden = 1'b1;
                        valid_d  = 1'b1;
                        data_d   = pld_rdata_i;
                        sop_d    = 1'b0;
                        eop_d    = pld_last_i;
                        if (pld_last_i) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pops are suppressed while reset is held so no FIFO entry is lost.
    assign hdr_rden_o = rst_n ? hdr_rden : '0;
    assign pld_rden_o = rst_n ? pld_rden : 1'b0;

    // State, round-robin pointer and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign tlp_valid_o = valid_q;
    assign tlp_data_o  = data_q;
    assign tlp_sop_o   = sop_q;
    assign tlp_eop_o   = eop_q;

`ifdef PCIE_TX_STATS_EN
    logic [IDX_W-1:0]        owner_q;
    logic [NUM_CH-1:0][31:0] tlp_cnt_q;
    logic [31:0]             stall_cnt_q;

    // Owner of the TLP currently on the output; it only changes on a header pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= '0;
        end else if (|hdr_rden) begin
            owner_q <= gnt_idx;
        end
    end

    // Saturating counters: accepted eop beats per owner, and stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlp_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid_q && tlp_ready_i && eop_q && (tlp_cnt_q[owner_q] != 32'hFFFF_FFFF)) begin
                tlp_cnt_q[owner_q] <= tlp_cnt_q[owner_q] + 32'd1;
            end
            if (valid_q && !tlp_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stat_tlp_cnt_o   = tlp_cnt_q;
    assign stat_stall_cnt_o = stall_cnt_q;
`else
    assign stat_tlp_cnt_o   = '0;
    assign stat_stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcie_tx_tlp_mux.sv
// ============================================================================
// Module      : tb_pcie_tx_tlp_mux
// Description : Directed self-checking bench for pcie_tx_tlp_mux (2 channels,
//               128-bit headers, 256-bit beats). Show-ahead FIFOs are modelled
//               as queues popped on the DUT's rden strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_tx_tlp_mux;

`ifdef PCIE_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [255:0] d;
        logic         last;
    } pld_t;

    typedef struct packed {
        logic [255:0] d;
        logic         sop;
        logic         eop;
        logic [31:0]  cyc;
    } beat_t;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           hdr_empty_i;
    logic [1:0][127:0]    hdr_rdata_i;
    logic [1:0]           hdr_rden_o;
    logic                 pld_empty_i;
    logic [255:0]         pld_rdata_i;
    logic                 pld_last_i;
    logic                 pld_rden_o;
    logic                 tlp_valid_o;
    logic                 tlp_ready_i;
    logic [255:0]         tlp_data_o;
    logic                 tlp_sop_o;
    logic                 tlp_eop_o;
    logic [1:0][31:0]     stat_tlp_cnt_o;
    logic [31:0]          stat_stall_cnt_o;

    logic [127:0] hq0[$];
    logic [127:0] hq1[$];
    pld_t         pq[$];
    beat_t        beats[$];
    logic         pld_hold;
    logic [1:0]   last_hr;
    logic         last_pr;
    int           cyc;
    int           hpop[2];
    int           hpop_cyc[2];
    int           last_pop_cyc;
    int           exp_tlp0;
    int           exp_tlp1;
    int           n_chk;
    int           n_fail;

    pcie_tx_tlp_mux #(
        .NUM_CH     (2),
        .HDR_WIDTH  (128),
        .DATA_WIDTH (256)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hdr_empty_i      (hdr_empty_i),
        .hdr_rdata_i      (hdr_rdata_i),
        .hdr_rden_o       (hdr_rden_o),
        .pld_empty_i      (pld_empty_i),
        .pld_rdata_i      (pld_rdata_i),
        .pld_last_i       (pld_last_i),
        .pld_rden_o       (pld_rden_o),
        .tlp_valid_o      (tlp_valid_o),
        .tlp_ready_i      (tlp_ready_i),
        .tlp_data_o       (tlp_data_o),
        .tlp_sop_o        (tlp_sop_o),
        .tlp_eop_o        (tlp_eop_o),
        .stat_tlp_cnt_o   (stat_tlp_cnt_o),
        .stat_stall_cnt_o (stat_stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present the FIFO heads to the DUT.
    task automatic drive_inputs();
        hdr_empty_i[0] = (hq0.size() == 0);
        hdr_rdata_i[0] = (hq0.size() != 0) ? hq0[0] : 128'h0;
        hdr_empty_i[1] = (hq1.size() == 0);
        hdr_rdata_i[1] = (hq1.size() != 0) ? hq1[0] : 128'h0;
        pld_empty_i    = pld_hold || (pq.size() == 0);
        pld_rdata_i    = (pq.size() != 0) ? pq[0].d : 256'h0;
        pld_last_i     = (pq.size() != 0) ? pq[0].last : 1'b0;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic tick();
        beat_t b;
        drive_inputs();
        #1;
        last_hr = hdr_rden_o;
        last_pr = pld_rden_o;
        n_chk++;
        if (((last_hr & hdr_empty_i) != 2'b00) || (last_pr && pld_empty_i) ||
            (last_pr && (last_hr != 2'b00)) || (last_hr == 2'b11)) begin
            n_fail++;
            $display("FAIL rden_rules cyc=%0d: hdr_rden=%b pld_rden=%b hdr_empty=%b pld_empty=%b, required one legal strobe at most",
                     cyc, last_hr, last_pr, hdr_empty_i, pld_empty_i);
        end
        if (tlp_valid_o === 1'b1 && tlp_ready_i) begin
            b.d = tlp_data_o; b.sop = tlp_sop_o; b.eop = tlp_eop_o; b.cyc = 32'(cyc);
            beats.push_back(b);
        end
        @(posedge clk);
        #1;
        if (last_hr[0]) begin void'(hq0.pop_front()); hpop[0]++; hpop_cyc[0] = cyc; end
        if (last_hr[1]) begin void'(hq1.pop_front()); hpop[1]++; hpop_cyc[1] = cyc; end
        if (last_pr) begin
            if (pq[0].last) last_pop_cyc = cyc;
            void'(pq.pop_front());
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hdr_empty_i = 2'b00; hdr_rdata_i[0] = 128'h4000_0000; hdr_rdata_i[1] = 128'h1;
        pld_empty_i = 1'b0; pld_rdata_i = 256'h55; pld_last_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({tlp_valid_o, tlp_sop_o, tlp_eop_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: valid/sop/eop=%b required 000", {tlp_valid_o, tlp_sop_o, tlp_eop_o}); end
        n_chk++; if (tlp_data_o !== 256'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", tlp_data_o); end
        n_chk++; if ({hdr_rden_o, pld_rden_o} !== 3'b000) begin n_fail++; $display("FAIL reset_rden: got %b required 000", {hdr_rden_o, pld_rden_o}); end
        n_chk++; if ({stat_tlp_cnt_o, stat_stall_cnt_o} !== 96'h0) begin n_fail++; $display("FAIL reset_stats: got %h required 0", {stat_tlp_cnt_o, stat_stall_cnt_o}); end
        drive_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (tlp_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_valid: got %b required 0", tlp_valid_o); end
    endtask

    task automatic test_single_nodata();
        int base;
        base = beats.size();
        hq1.push_back(128'h0);
        repeat (5) tick();
        exp_tlp1++;
        n_chk++; if (beats.size() - base != 1) begin n_fail++; $display("FAIL single_beats: got %0d beats required 1", beats.size() - base); end
        if (beats.size() > base) begin
            n_chk++; if ({beats[base].d, beats[base].sop, beats[base].eop} !== {256'h0, 2'b11}) begin n_fail++; $display("FAIL single_beat: data=%h sop=%b eop=%b required 0/1/1", beats[base].d, beats[base].sop, beats[base].eop); end
            n_chk++; if (beats[base].cyc !== 32'(hpop_cyc[1] + 1)) begin n_fail++; $display("FAIL single_latency: beat cyc %0d required %0d", beats[base].cyc, hpop_cyc[1] + 1); end
        end
        n_chk++; if (hpop[1] != 1 || hpop[0] != 0) begin n_fail++; $display("FAIL single_pops: ch0=%0d ch1=%0d required 0/1", hpop[0], hpop[1]); end
        n_chk++; if (stat_tlp_cnt_o[1] !== (STATS ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL single_stat1: got %0d required %0d", stat_tlp_cnt_o[1], STATS ? 1 : 0); end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [255:0] e;
        base = beats.size();
        for (int i = 0; i < 4; i++) begin
            hq0.push_back(128'h100 + 128'(i));
            hq1.push_back(128'h200 + 128'(i));
        end
        repeat (10) tick();
        exp_tlp0 += 4; exp_tlp1 += 4;
        n_chk++; if (beats.size() - base != 8) begin n_fail++; $display("FAIL b2b_beats: got %0d required 8", beats.size() - base); end
        for (int i = 0; i < 8 && base + i < beats.size(); i++) begin
            e = ((i % 2) == 0) ? (256'h100 + 256'(i / 2)) : (256'h200 + 256'(i / 2));
            n_chk++; if ({beats[base+i].d, beats[base+i].sop, beats[base+i].eop} !== {e, 2'b11}) begin n_fail++; $display("FAIL b2b_beat%0d: data=%h sop=%b eop=%b required %h/1/1", i, beats[base+i].d, beats[base+i].sop, beats[base+i].eop, e); end
            n_chk++; if (beats[base+i].cyc !== beats[base].cyc + 32'(i)) begin n_fail++; $display("FAIL b2b_cycle%0d: cyc %0d required %0d", i, beats[base+i].cyc, beats[base].cyc + 32'(i)); end
        end
    endtask

    task automatic test_payload();
        int base;
        logic [257:0] exp_b[4];
        base = beats.size();
        hq0.push_back(128'h1111_2222_3333_4444_5555_6666_4000_0001);
        pq.push_back({256'hA1, 1'b0}); pq.push_back({256'hA2, 1'b0}); pq.push_back({256'hA3, 1'b1});
        exp_b[0] = {128'h0, 128'h1111_2222_3333_4444_5555_6666_4000_0001, 2'b10};
        exp_b[1] = {256'hA1, 2'b00};
        exp_b[2] = {256'hA2, 2'b00};
        exp_b[3] = {256'hA3, 2'b01};
        repeat (8) tick();
        exp_tlp0++;
        n_chk++; if (beats.size() - base != 4) begin n_fail++; $display("FAIL pld_beats: got %0d required 4", beats.size() - base); end
        for (int i = 0; i < 4 && base + i < beats.size(); i++) begin
            n_chk++; if ({beats[base+i].d, beats[base+i].sop, beats[base+i].eop} !== exp_b[i]) begin n_fail++; $display("FAIL pld_beat%0d: got %h required %h", i, {beats[base+i].d, beats[base+i].sop, beats[base+i].eop}, exp_b[i]); end
        end
        n_chk++; if (pq.size() != 0) begin n_fail++; $display("FAIL pld_drained: %0d entries left required 0", pq.size()); end
        base = beats.size();
        hq1.push_back(128'h77);
        repeat (4) tick();
        exp_tlp1++;
        n_chk++; if (beats.size() - base != 1 || (beats.size() > base && {beats[base].d, beats[base].sop, beats[base].eop} !== {256'h77, 2'b11})) begin n_fail++; $display("FAIL pld_back_to_idle: %0d beats, required one header 77 sop/eop", beats.size() - base); end
    endtask

    task automatic test_stall();
        int base;
        base = beats.size();
        hq0.push_back(128'h4000_0002);
        pq.push_back({256'hB1, 1'b0}); pq.push_back({256'hB2, 1'b0}); pq.push_back({256'hB3, 1'b1});
        for (int k = 0; k < 20; k++) begin
            tick();
            if (beats.size() - base >= 2) break;
        end
        n_chk++; if (beats.size() - base < 2) begin n_fail++; $display("FAIL stall_setup_timeout: %0d beats required 2", beats.size() - base); end
        tlp_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++; if ({tlp_valid_o, tlp_data_o, tlp_sop_o, tlp_eop_o, last_hr, last_pr} !== {1'b1, 256'hB2, 2'b00, 3'b000}) begin n_fail++; $display("FAIL stall_hold%0d: valid=%b data=%h sop=%b eop=%b rden=%b%b required 1/B2/0/0/000", k, tlp_valid_o, tlp_data_o, tlp_sop_o, tlp_eop_o, last_hr, last_pr); end
        end
        n_chk++; if (stat_stall_cnt_o !== (STATS ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL stall_count: got %0d required %0d", stat_stall_cnt_o, STATS ? 5 : 0); end
        tlp_ready_i = 1'b1;
        repeat (6) tick();
        exp_tlp0++;
        n_chk++; if (beats.size() - base != 4) begin n_fail++; $display("FAIL stall_beats: got %0d required 4", beats.size() - base); end
        else begin
            n_chk++; if ({beats[base+3].d, beats[base+3].eop} !== {256'hB3, 1'b1}) begin n_fail++; $display("FAIL stall_last: got %h eop=%b required B3/1", beats[base+3].d, beats[base+3].eop); end
        end
        n_chk++; if (stat_tlp_cnt_o !== (STATS ? {32'(exp_tlp1), 32'(exp_tlp0)} : 64'h0)) begin n_fail++; $display("FAIL stall_tlp_stats: got %h required ch1=%0d ch0=%0d", stat_tlp_cnt_o, exp_tlp1, exp_tlp0); end
    endtask

    task automatic test_pld_empty_block();
        int base;
        int p0;
        base = beats.size();
        p0 = hpop[0];
        pld_hold = 1'b1;
        hq0.push_back(128'h4000_0003);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (hpop[0] != p0) break;
        end
        n_chk++; if (hpop[0] == p0) begin n_fail++; $display("FAIL blk_hdr_timeout: ch0 pops %0d required %0d", hpop[0], p0 + 1); end
        hq1.push_back(128'h300);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if ({last_hr, last_pr} !== 3'b000) begin n_fail++; $display("FAIL blk_no_grant%0d: rden=%b%b required 000", k, last_hr, last_pr); end
        end
        n_chk++; if (tlp_valid_o !== 1'b0) begin n_fail++; $display("FAIL blk_bubble: valid=%b required 0", tlp_valid_o); end
        pq.push_back({256'hC1, 1'b1});
        pld_hold = 1'b0;
        repeat (8) tick();
        exp_tlp0++; exp_tlp1++;
        n_chk++; if (beats.size() - base != 3) begin n_fail++; $display("FAIL blk_beats: got %0d required 3", beats.size() - base); end
        else begin
            n_chk++; if ({beats[base+1].d, beats[base+1].sop, beats[base+1].eop, beats[base+2].d, beats[base+2].sop, beats[base+2].eop} !== {256'hC1, 2'b01, 256'h300, 2'b11}) begin n_fail++; $display("FAIL blk_order: beat1=%h beat2=%h required C1(eop) then 300(sop/eop)", beats[base+1].d, beats[base+2].d); end
        end
        n_chk++; if (hpop_cyc[1] <= last_pop_cyc) begin n_fail++; $display("FAIL blk_grant_after_last: ch1 pop cyc %0d required after %0d", hpop_cyc[1], last_pop_cyc); end
        n_chk++; if (stat_tlp_cnt_o !== (STATS ? {32'(exp_tlp1), 32'(exp_tlp0)} : 64'h0)) begin n_fail++; $display("FAIL blk_tlp_stats: got %h required ch1=%0d ch0=%0d", stat_tlp_cnt_o, exp_tlp1, exp_tlp0); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = beats.size();
        hq0.push_back(128'h4000_0004);
        pq.push_back({256'hD1, 1'b0}); pq.push_back({256'hD2, 1'b0}); pq.push_back({256'hD3, 1'b1});
        for (int k = 0; k < 20; k++) begin
            tick();
            if (beats.size() - base >= 2) break;
        end
        n_chk++; if (tlp_data_o !== 256'hD2) begin n_fail++; $display("FAIL rmid_setup: data=%h required D2", tlp_data_o); end
        hq1.push_back(128'h400);
        rst_n = 1'b0;
        drive_inputs();
        #1;
        n_chk++; if ({tlp_valid_o, tlp_sop_o, tlp_eop_o, hdr_rden_o, pld_rden_o} !== 6'b0) begin n_fail++; $display("FAIL rmid_async: valid/sop/eop/rden=%b required 0", {tlp_valid_o, tlp_sop_o, tlp_eop_o, hdr_rden_o, pld_rden_o}); end
        n_chk++; if ({tlp_data_o, stat_tlp_cnt_o, stat_stall_cnt_o} !== 352'h0) begin n_fail++; $display("FAIL rmid_clear: data=%h stats=%h required 0", tlp_data_o, {stat_tlp_cnt_o, stat_stall_cnt_o}); end
        @(posedge clk);
        #1;
        repeat (2) tick();
        n_chk++; if (pq.size() != 1 || hq1.size() != 1) begin n_fail++; $display("FAIL rmid_no_discard: pld left %0d hdr1 left %0d required 1/1", pq.size(), hq1.size()); end
        rst_n = 1'b1;
        hq0.push_back(128'h500);
        base = beats.size();
        repeat (6) tick();
        n_chk++; if (beats.size() - base != 2) begin n_fail++; $display("FAIL rmid_beats: got %0d required 2", beats.size() - base); end
        else begin
            n_chk++; if ({beats[base].d, beats[base].sop, beats[base].eop, beats[base+1].d, beats[base+1].sop, beats[base+1].eop} !== {256'h500, 2'b11, 256'h400, 2'b11}) begin n_fail++; $display("FAIL rmid_order: beat0=%h beat1=%h required 500 then 400", beats[base].d, beats[base+1].d); end
        end
        n_chk++; if (stat_tlp_cnt_o !== (STATS ? {32'd1, 32'd1} : 64'h0)) begin n_fail++; $display("FAIL rmid_stats: got %h required %0d per channel", stat_tlp_cnt_o, STATS ? 1 : 0); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        hpop[0] = 0; hpop[1] = 0; hpop_cyc[0] = 0; hpop_cyc[1] = 0; last_pop_cyc = 0;
        exp_tlp0 = 0; exp_tlp1 = 0;
        last_hr = 2'b00; last_pr = 1'b0;
        pld_hold = 1'b0;
        tlp_ready_i = 1'b1;
        test_reset();
        test_single_nodata();
        test_back_to_back();
        test_payload();
        test_stall();
        test_pld_empty_block();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
